block_pe_elastic: RTL and testbench

BLOCK_PE_ELASTIC -- requirements
Module: block_pe_elastic

---
 rtl/pe_pkg.sv | 36 +++
 rtl/pe_out_fifo.sv | 49 ++++
 rtl/block_pe_elastic.sv | 127 ++++++++++++
 tb/tb_block_pe_elastic.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the elastic processing element: opcodes and config field offsets.
package pe_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } opcode_e;

  localparam int unsigned SEL_A_LSB = 0;

  // Config word layout, LSB first: sel_a | sel_b | opcode | acc_mode.
  function automatic int unsigned sel_b_lsb(input int unsigned selw);
    return selw;
  endfunction

  function automatic int unsigned opcode_lsb(input int unsigned selw);
    return 2 * selw;
  endfunction

  function automatic int unsigned acc_bit(input int unsigned selw);
    return 2 * selw + OP_W;
  endfunction

  function automatic int unsigned cfg_width(input int unsigned selw);
    return 2 * selw + OP_W + 1;
  endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// Two-entry valid/ready output FIFO; head data is driven straight from storage.
module pe_out_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push_ready = (count < 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/block_pe_elastic.sv
// Elastic processing element: serially configured operand mux + ALU feeding a 2-entry output FIFO.
module block_pe_elastic
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out0,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned SELW     = $clog2(NUM_IN + 1);
  localparam int unsigned CFG_W    = cfg_width(SELW);
  localparam int unsigned SELB_LSB = sel_b_lsb(SELW);
  localparam int unsigned OP_LSB   = opcode_lsb(SELW);
  localparam int unsigned ACC_BIT  = acc_bit(SELW);
  localparam int unsigned SHW      = $clog2(WIDTH);

  logic [CFG_W-1:0] cfg;
  logic [SELW-1:0]  sel_a;
  logic [SELW-1:0]  sel_b;
  opcode_e          opcode;
  logic             acc_mode;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             a_valid;
  logic             b_valid;
  logic [WIDTH-1:0] result;
  logic             fire;
  logic             push_ready;

  assign sel_a      = cfg[SEL_A_LSB +: SELW];
  assign sel_b      = cfg[SELB_LSB +: SELW];
  assign opcode     = opcode_e'(cfg[OP_LSB +: OP_W]);
  assign acc_mode   = cfg[ACC_BIT];
  assign config_out = cfg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else if (config_en) begin
      cfg <= {config_in, cfg[CFG_W-1:1]};
    end
  end

  // Operand mux: an out-of-range select yields an always-valid zero.
  always_comb begin
    a_data  = '0;
    a_valid = 1'b1;
    b_data  = '0;
    b_valid = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (SELW'(k) == sel_a) begin
        a_data  = in_data[k*WIDTH +: WIDTH];
        a_valid = in_valid[k];
      end
      if (SELW'(k) == sel_b) begin
        b_data  = in_data[k*WIDTH +: WIDTH];
        b_valid = in_valid[k];
      end
    end
    if (acc_mode) begin
      b_data  = acc;
      b_valid = 1'b1;
    end
  end

  always_comb begin
    result = a_data;
    case (opcode)
      OP_ADD:  result = a_data + b_data;
      OP_SUB:  result = a_data - b_data;
      OP_AND:  result = a_data & b_data;
      OP_OR:   result = a_data | b_data;
      OP_XOR:  result = a_data ^ b_data;
      OP_SHL:  result = a_data << b_data[SHW-1:0];
      OP_SHR:  result = a_data >> b_data[SHW-1:0];
      OP_PASS: result = a_data;
      default: result = a_data;
    endcase
  end

  assign fire = !reset && !config_en && a_valid && b_valid && push_ready;

  // A channel picked by both operands is consumed once.
  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      in_ready[k] = fire && ((SELW'(k) == sel_a) || ((SELW'(k) == sel_b) && !acc_mode));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (config_en) begin
      acc <= '0;
    end else if (fire && acc_mode) begin
      acc <= result;
    end
  end

  pe_out_fifo #(
    .WIDTH(WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_valid(fire),
    .push_data (result),
    .push_ready(push_ready),
    .pop_valid (out_valid),
    .pop_data  (out0),
    .pop_ready (out_ready)
  );

endmodule

// File: tb/tb_block_pe_elastic.sv
// Directed bench for block_pe_elastic: vector table for the ALU/mux plus multi-cycle sequences.
module tb_block_pe_elastic;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned NVEC   = 10;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    config_en;
  logic                    config_in;
  logic                    config_out;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out0;
  logic                    out_valid;
  logic                    out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  block_pe_elastic #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .reset     (reset),
    .config_en (config_en),
    .config_in (config_in),
    .config_out(config_out),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    in_data[k*WIDTH +: WIDTH] = v;
  endtask

  // Shifts a full config word in, bit 0 first so it lands at cfg[0].
  task automatic load_cfg(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] op,
                          input logic acc);
    logic [9:0] word;
    word = {acc, op, sb, sa};
    for (int i = 0; i < 10; i++) begin
      config_en = 1'b1;
      config_in = word[i];
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
    #1;
    check("config_out", 32'(config_out), 32'(word[0]));
  endtask

  initial begin
    vecs[0] = '{3'd1, 3'd2, 3'd0, 32'd5,          32'd7,          32'd12,         4'b0110};
    vecs[1] = '{3'd0, 3'd1, 3'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  4'b0011};
    vecs[2] = '{3'd0, 3'd1, 3'd5, 32'd1,          32'd33,         32'd2,          4'b0011};
    vecs[3] = '{3'd0, 3'd4, 3'd0, 32'd9,          32'd0,          32'd9,          4'b0001};
    vecs[4] = '{3'd3, 3'd3, 3'd4, 32'hA5,         32'hA5,         32'd0,          4'b1000};
    vecs[5] = '{3'd2, 3'd0, 3'd2, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  4'b0101};
    vecs[6] = '{3'd1, 3'd3, 3'd3, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  4'b1010};
    vecs[7] = '{3'd2, 3'd1, 3'd6, 32'h8000_0000,  32'd31,         32'd1,          4'b0110};
    vecs[8] = '{3'd3, 3'd0, 3'd7, 32'hDEAD_BEEF,  32'd5,          32'hDEAD_BEEF,  4'b1001};
    vecs[9] = '{3'd4, 3'd2, 3'd1, 32'd0,          32'd3,          32'hFFFF_FFFD,  4'b0100};

    reset     = 1'b1;
    config_en = 1'b0;
    config_in = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_config_out", 32'(config_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Single-transaction vectors: ready mask, one-cycle latency, then drain.
    for (int i = 0; i < int'(NVEC); i++) begin
      load_cfg(vecs[i].sa, vecs[i].sb, vecs[i].op, 1'b0);
      in_data   = '0;
      in_valid  = '0;
      out_ready = 1'b1;
      if (vecs[i].sa < 3'd4) begin
        set_ch(int'(vecs[i].sa), vecs[i].a);
        in_valid[vecs[i].sa[1:0]] = 1'b1;
      end
      if (vecs[i].sb < 3'd4 && vecs[i].sb != vecs[i].sa) begin
        set_ch(int'(vecs[i].sb), vecs[i].b);
        in_valid[vecs[i].sb[1:0]] = 1'b1;
      end
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].mask));
      check($sformatf("vec%0d_pre_valid", i), 32'(out_valid), 32'd0);
      tick();
      in_valid = '0;
      #1;
      check($sformatf("vec%0d_in_ready_off", i), 32'(in_ready), 32'd0);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_out0", i), out0, vecs[i].exp);
      tick();
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: two results fill the FIFO, the third pair is held.
    load_cfg(3'd1, 3'd2, 3'd0, 1'b0);
    out_ready = 1'b0;
    in_data   = '0;
    set_ch(1, 32'd1);
    set_ch(2, 32'd2);
    in_valid  = 4'b0110;
    tick();
    set_ch(1, 32'd10);
    set_ch(2, 32'd20);
    tick();
    set_ch(1, 32'd100);
    set_ch(2, 32'd200);
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_head0", out0, 32'd3);
    tick();
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_head", out0, 32'd3);
    out_ready = 1'b1;
    #1;
    check("bp_pop_cycle_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp_head1", out0, 32'd30);
    check("bp_third_in_ready", 32'(in_ready), 32'b0110);
    tick();
    in_valid = '0;
    #1;
    check("bp_head2", out0, 32'd300);
    check("bp_head2_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Accumulate: sel_b points at an idle channel, so firing proves it is ignored.
    load_cfg(3'd0, 3'd1, 3'd0, 1'b1);
    in_data = '0;
    for (int v = 1; v <= 4; v++) begin
      set_ch(0, 32'(v));
      in_valid = 4'b0001;
      #1;
      check($sformatf("acc%0d_in_ready", v), 32'(in_ready), 32'b0001);
      tick();
      in_valid = '0;
      check($sformatf("acc%0d_out0", v), out0, 32'(v * (v + 1) / 2));
      tick();
    end
    load_cfg(3'd0, 3'd1, 3'd0, 1'b1);
    set_ch(0, 32'd5);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    check("acc_restart_out0", out0, 32'd5);
    tick();

    // Reset with a full FIFO and a config whose bit 0 is set.
    load_cfg(3'd1, 3'd2, 3'd0, 1'b0);
    out_ready = 1'b0;
    set_ch(1, 32'd4);
    set_ch(2, 32'd4);
    in_valid = 4'b0110;
    tick();
    tick();
    in_valid = '0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_config_out", 32'(config_out), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    set_ch(0, 32'd3);
    in_valid  = 4'b0001;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    tick();
    in_valid = '0;
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_out0", out0, 32'd6);
    tick();
    check("post_rst_drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
